// File: rtl/divide_unit_if.sv
// ---------------------------------------------------------------------------
// divide_unit_if
// Request/response bundle for the iterative divider.
//   start  : request a new division (master -> slave)
//   a, b   : dividend / divisor, 32 bits (master -> slave)
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU (master -> slave)
//   busy   : operation in progress (slave -> master)
//   valid  : one-cycle result strobe (slave -> master)
//   result : quotient or remainder (slave -> master)
// ---------------------------------------------------------------------------
interface divide_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    modport master (
        output start, a, b, op,
        input  busy, valid, result
    );

    modport slave (
        input  start, a, b, op,
        output busy, valid, result
    );
endinterface

// File: rtl/divide_unit.sv
// ---------------------------------------------------------------------------
// divide_unit
// 32-bit signed/unsigned divider using restoring shift-subtract, one
// iteration per clock. Start-to-valid latency is 34 cycles: 32 iterations
// followed by one sign-correction cycle, then a one-cycle DONE.
//
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : divide_unit_if.slave (start, a, b, op in; busy, valid, result out)
//
// Optional feature macro: DIVIDE_ZERO_BYPASS_EN
//   When defined, a request with b == 0 jumps straight to DONE (valid one
//   cycle after acceptance). Result values are identical either way.
// ---------------------------------------------------------------------------
module divide_unit (
    input  logic          clk,
    input  logic          rstn,
    divide_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        last_q;     // all 32 iterations done, next CALC cycle is fix-up
    logic [31:0] rem_q;      // partial remainder
    logic [31:0] quo_q;      // dividend shifting out / quotient shifting in
    logic [31:0] dvs_q;      // divisor magnitude
    logic [31:0] a_q;        // original dividend, needed for divide-by-zero REM
    logic [1:0]  op_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [31:0] result_q;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        zero_bypass;
    logic [32:0] r_shift, diff;
    logic        fit;
    logic [31:0] rem_next;
    logic [31:0] final_res;

    assign accept = (state_q == IDLE) && bus.start;

    // op[0] set means unsigned; magnitudes come straight from the inputs
    assign a_neg = ~bus.op[0] & bus.a[31];
    assign b_neg = ~bus.op[0] & bus.b[31];
    assign a_mag = a_neg ? (32'd0 - bus.a) : bus.a;
    assign b_mag = b_neg ? (32'd0 - bus.b) : bus.b;

`ifdef DIVIDE_ZERO_BYPASS_EN
    assign zero_bypass = (bus.b == 32'd0);
`else
    assign zero_bypass = 1'b0;
`endif

    // One restoring step: shift next dividend bit in, try to subtract.
    assign r_shift  = {rem_q, quo_q[31]};
    assign diff     = r_shift - {1'b0, dvs_q};
    assign fit      = ~diff[32];
    assign rem_next = fit ? diff[31:0] : r_shift[31:0];

    // Sign correction. A zero divisor is decoded explicitly so signed DIV
    // by zero still yields all ones instead of a negated quotient.
    always_comb begin
        final_res = quo_q;
        if (dvs_q == 32'd0)
            final_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
        else if (op_q[1])
            final_res = rneg_q ? (32'd0 - rem_q) : rem_q;
        else
            final_res = qneg_q ? (32'd0 - quo_q) : quo_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = zero_bypass ? DONE : CALC;
            CALC:    if (last_q)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= 5'd0;
            last_q   <= 1'b0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            a_q      <= 32'd0;
            op_q     <= 2'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
        end else if (accept) begin
            cnt_q  <= 5'd0;
            last_q <= 1'b0;
            rem_q  <= 32'd0;
            quo_q  <= a_mag;
            dvs_q  <= b_mag;
            a_q    <= bus.a;
            op_q   <= bus.op;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (zero_bypass)
                result_q <= bus.op[1] ? bus.a : 32'hFFFF_FFFF;
        end else if (state_q == CALC) begin
            if (!last_q) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[30:0], fit};
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    last_q <= 1'b1;
            end else begin
                result_q <= final_res;
            end
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.valid  = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_divide_unit.sv
module tb_divide_unit;
    logic clk;
    logic rstn;
    divide_unit_if bus ();

    divide_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   n_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers, truncating division.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        longint sa, sb2, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa  = {32'd0, a};
            sb2 = {32'd0, b};
        end else begin
            sa  = $signed(a);
            sb2 = $signed(b);
        end
        r = op[1] ? (sa % sb2) : (sa / sb2);
        return r[31:0];
    endfunction

    // Monitor: pops one expectation per valid pulse.
    always @(negedge clk) begin
        if (bus.valid) begin
            exp_t e;
            n_valid++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got result %h expected no pulse", bus.result);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("latency", cyc - e.acc, e.lat);
                $display("txn result=%h expected=%h latency=%0d", bus.result, e.res, cyc - e.acc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t e;
        int   guard = 0;
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy 1 expected 0");
        end
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        bus.start = 1'b1;
        e.res = model(a, b, op);
        e.acc = cyc + 1;
`ifdef DIVIDE_ZERO_BYPASS_EN
        e.lat = (b == 32'd0) ? 0 : 33;
`else
        e.lat = 33;
`endif
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || bus.busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          busy_cnt, g, v0;

        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.op    = 2'd0;
        #12;
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.valid, 0);
        check("reset_result", bus.result, 0);
        @(negedge clk);
        rstn = 1'b1;

        // DIVU 100/7 straight after reset release, counting busy cycles
        issue(32'd100, 32'd7, 2'b01);
        busy_cnt = bus.busy ? 1 : 0;
        g = 0;
        while (bus.busy && g < 100) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            g++;
        end
        check("busy_cycles", busy_cnt, 34);
        drain();

        issue(32'hFFFF_FFF9, 32'd2, 2'b00);
        issue(32'hFFFF_FFF9, 32'd2, 2'b10);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b10);
        issue(32'd5, 32'd0, 2'b01);
        issue(32'd5, 32'd0, 2'b11);
        issue(32'hFFFF_FFF0, 32'd0, 2'b00);
        issue(32'hFFFF_FFF0, 32'd0, 2'b10);
        drain();

        // Start while busy must be ignored
        v0 = n_valid;
        issue(32'd100, 32'd7, 2'b01);
        repeat (4) @(negedge clk);
        check("busy_at_second_start", bus.busy, 1);
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.op    = 2'b01;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("busy_start_pulses", n_valid - v0, 1);

        // Reset mid-operation
        issue(32'd12345, 32'd17, 2'b01);
        repeat (8) @(negedge clk);
        #2 rstn = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.valid, 0);
        check("abort_result", bus.result, 0);
        v0 = n_valid;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_pulse", n_valid - v0, 0);
        issue(32'd12345, 32'd17, 2'b01);
        drain();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 200);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            issue(ra, rb, 2'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/divide_unit.md
DIVIDE_UNIT -- requirements
Module: divide_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-002 The block SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL provide port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL provide port start, input, 1 bit: request a new division, sampled on the rising edge of clk.
REQ-005 The block SHALL provide port a, input, 32 bits: dividend, captured when start is accepted.
REQ-006 The block SHALL provide port b, input, 32 bits: divisor, captured when start is accepted.
REQ-007 The block SHALL provide port op, input, 2 bits: 00 = DIV (signed quotient), 01 = DIVU, 10 = REM (signed remainder), 11 = REMU; captured when start is accepted.
REQ-008 The block SHALL provide port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL provide port valid, output, 1 bit: one-cycle pulse marking that result is complete.
REQ-010 The block SHALL provide port result, output, 32 bits: quotient or remainder, selected by op.

Function
REQ-011 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-012 start SHALL be accepted only when busy is 0; the accepting edge SHALL capture a, b and op.
REQ-013 Operand inputs SHALL be ignored at every edge other than the accepting edge.
REQ-014 start asserted while busy is 1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-015 On acceptance, the FSM SHALL move from IDLE to CALC.
REQ-016 CALC SHALL perform exactly 32 restoring shift-subtract iterations on unsigned magnitudes, one iteration per cycle, counted by a 5-bit counter.
REQ-017 After the 32nd iteration, the FSM SHALL move from CALC to DONE.
REQ-018 From DONE, the FSM SHALL move to IDLE on the next edge.
REQ-019 valid SHALL be 1 only in DONE, so it is exactly one cycle wide.
REQ-020 busy SHALL be 1 in CALC and in DONE.
REQ-021 A start accepted at edge N SHALL put valid high during the cycle after edge N+33 (34-cycle latency).
REQ-022 For signed ops (DIV, REM), the block SHALL convert operands to magnitudes before iterating.
REQ-023 For signed ops, the quotient SHALL be negated when the operand signs differ.
REQ-024 For signed ops, the remainder SHALL take the sign of the dividend.
REQ-025 Division SHALL truncate toward zero.
REQ-026 Divide by zero SHALL give: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder equal to a, with no exception.
REQ-027 Signed overflow, a = 0x80000000 and b = 0xFFFFFFFF, SHALL give DIV = 0x80000000 and REM = 0.
REQ-028 result SHALL hold its value from DONE until the next accepted start; its value during CALC is don't-care.

Reset
REQ-029 While rstn = 0, the block SHALL asynchronously force: state = IDLE, busy = 0, valid = 0, result = 0, iteration counter = 0, internal operand registers = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no valid pulse SHALL follow.
REQ-031 After rstn deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-032 The macro DIVIDE_ZERO_BYPASS_EN SHALL select the divide-by-zero path.
REQ-033 With DIVIDE_ZERO_BYPASS_EN defined, an accepted start with b = 0 SHALL move IDLE directly to DONE, skipping CALC.
REQ-034 With DIVIDE_ZERO_BYPASS_EN defined, valid SHALL therefore be high during the cycle after the accepting edge (1-cycle latency).
REQ-035 With DIVIDE_ZERO_BYPASS_EN undefined, b = 0 SHALL take the full 34-cycle path.
REQ-036 Result values for b = 0 SHALL be identical (REQ-026) whether or not DIVIDE_ZERO_BYPASS_EN is defined; only latency differs.
REQ-037 DIVIDE_ZERO_BYPASS_EN SHALL leave behaviour for b != 0 unchanged.

Verification
REQ-038 DIVU test: a = 100, b = 7, op = 01 -> result = 14; valid high exactly 34 cycles after the accepting edge; busy high for 34 cycles.
REQ-039 Signed test: a = 0xFFFFFFF9 (-7), b = 2 -> DIV result = 0xFFFFFFFD (-3); REM result = 0xFFFFFFFF (-1).
REQ-040 Overflow test: a = 0x80000000, b = 0xFFFFFFFF -> DIV result = 0x80000000; REM result = 0x00000000; no hang.
REQ-041 Divide-by-zero test: a = 5, b = 0 -> DIVU result = 0xFFFFFFFF; REMU result = 5; latency 1 cycle with DIVIDE_ZERO_BYPASS_EN, 34 cycles without.
REQ-042 Busy-start test: start DIVU 100/7, then pulse start with a = 9, b = 3 at cycle 5 -> the second request is ignored; result = 14; exactly one valid pulse.
REQ-043 Reset test: start an operation, drive rstn = 0 at cycle 10 -> busy and valid drop immediately with no clock edge; no valid pulse follows; a new start after release completes correctly.
